// File: rtl/i2c_passthru_arb_ctrl.sv
// i2c_passthru_arb_ctrl
//   Bus-state tracker and arbitration guard for an I2C passthru. It watches
//   the SCL/SDA pads for START/STOP, forcibly releases SDA when another
//   master wins arbitration, and holds the bus busy until the bus-free time
//   (counted in i_f_ref rising edges of idle bus) has elapsed after a STOP.
//
// Ports
//   i_clk         sole clock, all state changes on its rising edge
//   i_rst         synchronous active-high reset
//   i_f_ref       slow reference clock, rising edge used as timer tick
//   i_scl_padin   SCL level at the pad
//   i_sda_padin   SDA level at the pad
//   i_sda_out     SDA level requested by the passthru FSM (0 = pull low)
//   i_mismatch    SDA mismatch detector flag
//   o_sda_padout  registered SDA drive level (1 = release)
//   o_arb_lost    one-cycle pulse on the ACTIVE -> LOST transition
//   o_lost        high while the drive is forcibly released
//   o_bus_busy    high from START until the bus-free time has elapsed
module i2c_passthru_arb_ctrl #(
  parameter int F_REF_T_BUF = 10,
  parameter int WIDTH_F_REF = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_f_ref,
  input  logic i_scl_padin,
  input  logic i_sda_padin,
  input  logic i_sda_out,
  input  logic i_mismatch,
  output logic o_sda_padout,
  output logic o_arb_lost,
  output logic o_lost,
  output logic o_bus_busy
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOST   = 2'd2,
    ST_TBUF   = 2'd3
  } state_t;

  localparam logic [WIDTH_F_REF-1:0] TBUF_LOAD = WIDTH_F_REF'(F_REF_T_BUF);
  localparam logic [WIDTH_F_REF-1:0] TIMER_ONE = WIDTH_F_REF'(1);

  state_t                 state_q, state_d;
  logic [WIDTH_F_REF-1:0] timer_q, timer_d;
  logic                   prev_scl_q, prev_sda_q, prev_f_ref_q;
  logic                   sda_padout_q, sda_padout_d;

  logic start_det, stop_det, tick, loss_cond, pads_idle, arb_lost;

  always_comb begin
    start_det = prev_scl_q & i_scl_padin & prev_sda_q & ~i_sda_padin;
    stop_det  = prev_scl_q & i_scl_padin & ~prev_sda_q & i_sda_padin;
    tick      = ~prev_f_ref_q & i_f_ref;
    // We released SDA (want 1) but the pad reads 0 during SCL high:
    // another master is driving the bus.
    loss_cond = i_mismatch & i_scl_padin & i_sda_out & ~i_sda_padin;
    pads_idle = i_scl_padin & i_sda_padin;

    state_d  = state_q;
    timer_d  = timer_q;
    arb_lost = 1'b0;

    case (state_q)
      ST_FREE: begin
        if (start_det) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // STOP has priority over a loss seen in the same cycle.
        if (stop_det) begin
          state_d = ST_TBUF;
        end else if (loss_cond) begin
          state_d  = ST_LOST;
          arb_lost = 1'b1;
        end
      end
      ST_LOST: begin
        // A repeated START keeps us off the bus; only STOP frees it.
        if (stop_det) state_d = ST_TBUF;
      end
      ST_TBUF: begin
        if (start_det) begin
          state_d = ST_ACTIVE;
        end else if (timer_q == '0) begin
          state_d = ST_FREE;
        end else if (!pads_idle) begin
          // Any pad activity restarts the bus-free window.
          timer_d = TBUF_LOAD;
        end else if (tick) begin
          // Reaching this branch implies timer_q != 0, so no wrap.
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = ST_FREE;
      end
    endcase

    if ((state_q != ST_TBUF) && (state_d == ST_TBUF)) timer_d = TBUF_LOAD;

    sda_padout_d = (state_d == ST_LOST) ? 1'b1 : i_sda_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_FREE;
      timer_q      <= TBUF_LOAD;
      prev_scl_q   <= 1'b1;
      prev_sda_q   <= 1'b1;
      prev_f_ref_q <= 1'b0;
      sda_padout_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_scl_q   <= i_scl_padin;
      prev_sda_q   <= i_sda_padin;
      prev_f_ref_q <= i_f_ref;
      sda_padout_q <= sda_padout_d;
    end
  end

  assign o_sda_padout = sda_padout_q;
  assign o_lost       = (state_q == ST_LOST);
  assign o_bus_busy   = (state_q != ST_FREE);
  // Combinational Mealy pulse; masked during reset so it never fires then.
  assign o_arb_lost   = arb_lost & ~i_rst;

endmodule

// File: tb/tb_i2c_passthru_arb_ctrl.sv
// Randomized bench for i2c_passthru_arb_ctrl with a scoreboard. The driver
// applies one input vector per clock, advances a bus-level reference model
// and queues the outputs expected for that cycle; a monitor on the falling
// edge pops and compares them.
module tb_i2c_passthru_arb_ctrl;

  localparam int TBUF = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst, i_f_ref, i_scl_padin, i_sda_padin, i_sda_out, i_mismatch;
  logic o_sda_padout, o_arb_lost, o_lost, o_bus_busy;

  i2c_passthru_arb_ctrl #(.F_REF_T_BUF(TBUF), .WIDTH_F_REF(4)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_f_ref     (i_f_ref),
    .i_scl_padin (i_scl_padin),
    .i_sda_padin (i_sda_padin),
    .i_sda_out   (i_sda_out),
    .i_mismatch  (i_mismatch),
    .o_sda_padout(o_sda_padout),
    .o_arb_lost  (o_arb_lost),
    .o_lost      (o_lost),
    .o_bus_busy  (o_bus_busy)
  );

  typedef struct packed {
    logic busy;
    logic lost;
    logic arb;
    logic sda;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: bus is held (busy), we may be locked out (lost),
  // or we are waiting out the bus-free window (in_buf, with ticks left).
  bit m_known = 0;
  bit m_busy, m_lost, m_in_buf, m_sda;
  int m_left;
  bit m_pscl, m_psda, m_pfref;

  bit scl = 1, sda = 1, fr = 0;

  task automatic step(input bit r, input bit s, input bit d, input bit f,
                      input bit so, input bit mm);
    bit   st, sp, tk, loss, mine;
    exp_t e;
    @(posedge clk);
    #1;
    i_rst = r; i_scl_padin = s; i_sda_padin = d; i_f_ref = f;
    i_sda_out = so; i_mismatch = mm;

    st   = m_pscl && s && m_psda && !d;
    sp   = m_pscl && s && !m_psda && d;
    tk   = !m_pfref && f;
    loss = mm && s && so && !d;
    mine = m_busy && !m_lost && !m_in_buf;

    if (m_known) begin
      e.busy = m_busy;
      e.lost = m_lost;
      e.arb  = !r && mine && !sp && loss;
      e.sda  = m_sda;
      exp_q.push_back(e);
    end

    if (r) begin
      m_busy = 0; m_lost = 0; m_in_buf = 0; m_left = TBUF; m_sda = 1;
      m_pscl = 1; m_psda = 1; m_pfref = 0;
    end else begin
      if (!m_busy) begin
        if (st) m_busy = 1;
      end else if (m_in_buf) begin
        if (st) m_in_buf = 0;
        else if (m_left == 0) begin m_busy = 0; m_in_buf = 0; end
        else if (!(s && d)) m_left = TBUF;
        else if (tk) m_left = m_left - 1;
      end else if (m_lost) begin
        if (sp) begin m_lost = 0; m_in_buf = 1; m_left = TBUF; end
      end else begin
        if (sp) begin m_in_buf = 1; m_left = TBUF; end
        else if (loss) m_lost = 1;
      end
      m_sda  = m_lost ? 1'b1 : so;
      m_pscl = s; m_psda = d; m_pfref = f;
    end
    m_known = 1;
  endtask

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bus_busy",   o_bus_busy,   e.busy);
        check("lost",       o_lost,       e.lost);
        check("arb_lost",   o_arb_lost,   e.arb);
        check("sda_padout", o_sda_padout, e.sda);
      end
    end
  end

  initial begin
    int mode, len, wait_cyc;
    i_rst = 1; i_f_ref = 0; i_scl_padin = 1; i_sda_padin = 1;
    i_sda_out = 1; i_mismatch = 0;

    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 0, 1);
    fr = 0; scl = 1; sda = 1;

    for (int seg = 0; seg < 260; seg++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0, 1, 2: begin
          // Idle bus with reference ticks; occasional SCL glitch restarts
          // the window, and a START is sometimes timed to the last tick.
          len = $urandom_range(30, 90);
          for (int i = 0; i < len; i++) begin
            scl = 1; sda = 1;
            if ($urandom_range(0, 39) == 0) scl = 0;
            if (m_in_buf && m_left == 0 && m_pscl && m_psda && $urandom_range(0, 1) == 1) begin
              scl = 1; sda = 0;
            end else if ($urandom_range(0, 59) == 0) begin
              scl = 1; sda = 0;
            end
            if ($urandom_range(0, 1) == 1) fr = !fr;
            step(0, scl, sda, fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          end
        end
        3, 4: begin
          scl = 1; sda = 1;
          step(0, scl, sda, fr, 1, 0);
          sda = 0;
          step(0, scl, sda, fr, 0, 0);
          step(0, scl, sda, fr, 0, 0);
        end
        5: begin
          scl = 1; sda = 0;
          step(0, scl, sda, fr, 1, 0);
          sda = 1;
          step(0, scl, sda, fr, 1, 0);
        end
        6, 7: begin
          len = $urandom_range(5, 30);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 2) == 0) scl = !scl;
            if ($urandom_range(0, 2) == 0) sda = !sda;
            fr = 1'($urandom_range(0, 1));
            step(0, scl, sda, fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          end
        end
        8: begin
          // START, then another master pulls SDA low while we release it.
          scl = 1; sda = 1;
          step(0, scl, sda, fr, 1, 0);
          sda = 0;
          step(0, scl, sda, fr, 1, 0);
          step(0, scl, sda, fr, 1, 1);
          for (int i = 0; i < 4; i++)
            step(0, scl, sda, fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        default: begin
          if ($urandom_range(0, 2) == 0) begin
            len = $urandom_range(1, 2);
            for (int i = 0; i < len; i++)
              step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
          end else begin
            step(0, scl, sda, fr, 1'($urandom_range(0, 1)), 0);
          end
        end
      endcase
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_arb_ctrl.md
I2C_PASSTHRU_ARB_CTRL -- requirements
Module: i2c_passthru_arb_ctrl

Interface
REQ-001 SHALL have parameter F_REF_T_BUF, default 10: number of i_f_ref rising edges of bus-idle (SCL and SDA both high) after STOP before the bus is declared free; minimum 2.
REQ-002 SHALL have parameter WIDTH_F_REF, default 4: timer width, equal to CEILING(LOG2(F_REF_T_BUF+1)).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_f_ref  input  1  slow reference clock, sampled in i_clk domain; only its rising edge is used.
REQ-006 SHALL have port i_scl_padin  input  1  SCL level coming into FPGA.
REQ-007 SHALL have port i_sda_padin  input  1  SDA level coming into FPGA.
REQ-008 SHALL have port i_sda_out  input  1  SDA level requested by the upstream passthru FSM (0 = pull low, 1 = release).
REQ-009 SHALL have port i_mismatch  input  1  mismatch flag from the SDA mismatch detector monitoring o_sda_padout against i_sda_padin.
REQ-010 SHALL have port o_sda_padout  output  1  SDA level leaving FPGA, registered.
REQ-011 SHALL have port o_arb_lost  output  1  one-cycle pulse on arbitration loss.
REQ-012 SHALL have port o_lost  output  1  level, high while drive is forcibly released.
REQ-013 SHALL have port o_bus_busy  output  1  level, high from START until bus-free time elapses.

Function
REQ-014 SHALL register prev_scl, prev_sda and prev_f_ref each i_clk cycle; tick = ~prev_f_ref & i_f_ref.
REQ-015 SHALL detect START when prev_scl & i_scl_padin & prev_sda & ~i_sda_padin (SDA falls while SCL high in both samples).
REQ-016 SHALL detect STOP when prev_scl & i_scl_padin & ~prev_sda & i_sda_padin.
REQ-017 SHALL implement FSM with states ST_FREE, ST_ACTIVE, ST_LOST, ST_TBUF; illegal encodings go to ST_FREE next cycle.
REQ-018 ST_FREE: o_bus_busy=0; START -> ST_ACTIVE; i_mismatch ignored.
REQ-019 ST_ACTIVE: o_bus_busy=1; STOP -> ST_TBUF; else arbitration-loss condition (i_mismatch & i_scl_padin & i_sda_out & ~i_sda_padin) -> ST_LOST.
REQ-020 SHALL assert o_arb_lost for exactly the one cycle in which ST_ACTIVE -> ST_LOST is taken.
REQ-021 ST_LOST: o_lost=1, o_bus_busy=1; remain until STOP -> ST_TBUF; a repeated START does not leave ST_LOST.
REQ-022 ST_TBUF: o_bus_busy=1; START -> ST_ACTIVE; timer==0 -> ST_FREE.
REQ-023 Timer SHALL load F_REF_T_BUF on every transition into ST_TBUF and whenever i_scl_padin==0 or i_sda_padin==0 while in ST_TBUF.
REQ-024 Timer SHALL decrement by 1 on tick while in ST_TBUF with both pads high; SHALL saturate at 0, never wrap.
REQ-025 o_sda_padout SHALL be registered: next value 1 when next state is ST_LOST, else i_sda_out; one-cycle latency from i_sda_out.
REQ-026 Simultaneous STOP and arbitration-loss condition in ST_ACTIVE: STOP wins, go to ST_TBUF, no o_arb_lost pulse.
REQ-027 Simultaneous START and timer==0 in ST_TBUF: START wins, go to ST_ACTIVE.
REQ-028 o_lost and o_bus_busy SHALL be decoded from current state; o_arb_lost from current state and inputs, glitch-free at cycle boundary.

Reset
REQ-029 On i_clk edge with i_rst=1: state=ST_FREE, timer=F_REF_T_BUF, prev_scl=1, prev_sda=1, prev_f_ref=0, o_sda_padout=1.
REQ-030 Outputs during/after reset: o_arb_lost=0, o_lost=0, o_bus_busy=0, o_sda_padout=1.
REQ-031 Reset asserted mid-transfer (any state) SHALL release SDA (o_sda_padout=1) on the next edge, without waiting for STOP.

Verification
REQ-032 START (SDA 1->0, SCL=1) then i_sda_out=0 -> o_bus_busy=1 next cycle, o_sda_padout=0 one cycle after i_sda_out, o_arb_lost stays 0.
REQ-033 In ST_ACTIVE, i_sda_out=1, i_sda_padin=0, i_scl_padin=1, i_mismatch=1 -> o_arb_lost=1 for 1 cycle, o_lost=1, o_sda_padout=1 while i_sda_out toggles.
REQ-034 ST_LOST then STOP, pads held high, F_REF_T_BUF=10 -> o_bus_busy falls on the cycle after the 10th i_f_ref rising edge; SCL pulled low at edge 5 restarts count to 10.
REQ-035 Same cycle STOP and loss condition in ST_ACTIVE -> no o_arb_lost pulse, state ST_TBUF, o_lost=0.
REQ-036 ST_TBUF with START on the cycle timer reaches 0 -> ST_ACTIVE, o_bus_busy stays 1 continuously.
REQ-037 i_rst=1 asserted in ST_LOST -> next cycle o_lost=0, o_bus_busy=0, o_sda_padout=1; subsequent START -> ST_ACTIVE normally.
